apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
Converts a simple host command interface (valid/ready request, single-cycle response pulse) into APB3/APB4-style transfers toward the team's APB memory slave. Sequences IDLE -> SETUP -> ACCESS and waits on PREADY. Returns read data using the slave's one-cycle-registered PRDATA timing. Sits directly upstream of the APB slave; one outstanding transfer at a time.

Parameters:
ADDWIDTH, 8, width of cmd_addr/PADDR
DATAWIDTH, 32, width of data buses; multiple of 8
RDATA_LAT, 1, PRDATA sampling: 0 = at completing ACCESS edge (standard APB), 1 = one cycle after (registered-PRDATA slave)
TIMEOUT_CYCLES, 16, max ACCESS wait cycles with PREADY low (used only with the optional feature)

Ports:
PCLK  input  1  clock, all logic on rising edge
PRESET  input  1  reset, asynchronous, active-high
cmd_valid  input  1  host request valid
cmd_ready  output  1  bridge accepts request (high only in IDLE)
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDWIDTH  transfer address
cmd_wdata  input  DATAWIDTH  write data
cmd_strb  input  DATAWIDTH/8  byte strobes for writes
rsp_valid  output  1  one-cycle pulse: transfer complete
rsp_rdata  output  DATAWIDTH  read data, valid with rsp_valid (0 for writes)
rsp_err  output  1  transfer aborted, valid with rsp_valid
PSEL, PENABLE, PWRITE  output  1  APB control
PADDR  output  ADDWIDTH  APB address
PWDATA  output  DATAWIDTH  APB write data
PSTRB  output  DATAWIDTH/8  APB strobes
PREADY  input  1  slave ready
PRDATA  input  DATAWIDTH  slave read data

Behaviour:
- Reset (PRESET=1, async): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err all 0; cmd_ready=0 while PRESET=1, 1 in first IDLE cycle after release.
- Every APB output and every rsp_* output is a register output; cmd_ready is decoded from state.
- States: IDLE, SETUP, ACCESS, RDWAIT.
- IDLE: cmd_ready=1. On cmd_valid: latch cmd_* into PADDR/PWRITE/PWDATA; PSTRB = cmd_strb for writes, 0 for reads; PSEL<=1; -> SETUP.
- SETUP: PSEL=1, PENABLE=0, one cycle; PENABLE<=1; -> ACCESS.
- ACCESS: PSEL=PENABLE=1; address, data and control held stable until completion. PREADY=0: stay.
- PREADY=1, write or RDATA_LAT=0: PSEL, PENABLE <= 0; rsp_valid<=1 next cycle; rsp_rdata = PRDATA sampled at this edge for reads, 0 for writes; -> IDLE.
- PREADY=1, read with RDATA_LAT=1: PSEL, PENABLE <= 0; -> RDWAIT.
- RDWAIT: one cycle; sample PRDATA into rsp_rdata; rsp_valid<=1; -> IDLE.
- rsp_valid is high exactly one cycle and has no backpressure. rsp_rdata holds its value until the next response.
- Latency, cmd accept edge to rsp_valid high: write 3 cycles with zero-wait slave; read 4 cycles with RDATA_LAT=1; each PREADY-low cycle adds 1.
- Back-to-back: the earliest next accept is the IDLE cycle following completion. PSEL deasserts for at least one cycle between transfers.
- cmd_* are ignored outside IDLE. The host must hold cmd_* stable only in the accept cycle.
- Reset mid-transfer: immediate abort; all outputs return to reset values; no rsp_valid is generated.

Optional Feature:
Macro APB_MASTER_TIMEOUT_EN.
- Defined: a wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. If it reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts: PSEL, PENABLE <= 0; rsp_valid=1, rsp_err=1, rsp_rdata=0; -> IDLE (RDWAIT is skipped).
- Not defined: no counter; ACCESS waits indefinitely; rsp_err is constant 0.

Test Plan:
- Write: cmd addr=0x10, wdata=0xDEADBEEF, strb=4'hF, PREADY tied to PSEL&PENABLE -> SETUP one cycle, ACCESS one cycle with PSTRB=F; rsp_valid 3 cycles after accept; rsp_err=0.
- Read-back with RDATA_LAT=1 against the slave model: read 0x10 -> PSTRB=0 during the transfer; rsp_valid 4 cycles after accept; rsp_rdata=0xDEADBEEF.
- Partial strobe: write 0x11223344 strb=4'b0101 over 0xDEADBEEF, then read -> rsp_rdata=0xDE22BE44.
- Wait states: PREADY held low for 3 ACCESS cycles -> PADDR, PWDATA, PWRITE stable throughout; rsp_valid 3 cycles later than the zero-wait case.
- Reset mid-ACCESS: assert PRESET asynchronously between edges -> PSEL and PENABLE drop immediately, no rsp_valid, next command completes normally.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY stuck at 0 -> abort after 4 wait cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0; cmd_ready=1 the next cycle.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Host command (valid/ready, single-cycle response) to APB3/APB4 master bridge; one transfer in flight.
// Optional ACCESS wait timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDWIDTH       = 8,
    parameter int DATAWIDTH      = 32,
    parameter int RDATA_LAT      = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDWIDTH-1:0]    cmd_addr,
    input  logic [DATAWIDTH-1:0]   cmd_wdata,
    input  logic [DATAWIDTH/8-1:0] cmd_strb,
    output logic                   rsp_valid,
    output logic [DATAWIDTH-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [ADDWIDTH-1:0]    PADDR,
    output logic [DATAWIDTH-1:0]   PWDATA,
    output logic [DATAWIDTH/8-1:0] PSTRB,
    input  logic                   PREADY,
    input  logic [DATAWIDTH-1:0]   PRDATA
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RDWAIT} state_t;

    state_t                 state, state_n;
    logic                   psel_n, penable_n, pwrite_n, rsp_valid_n, rsp_err_n;
    logic [ADDWIDTH-1:0]    paddr_n;
    logic [DATAWIDTH-1:0]   pwdata_n, rsp_rdata_n;
    logic [DATAWIDTH/8-1:0] pstrb_n;
    logic                   timeout_hit;

    // Held low through reset so the host never sees a ready before release.
    assign cmd_ready = (state == IDLE) && !PRESET;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNTW-1:0] wait_cnt;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            wait_cnt <= '0;
        else if (state == SETUP)
            wait_cnt <= '0;
        else if (state == ACCESS && !PREADY)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle with PREADY low.
    assign timeout_hit = (state == ACCESS) && !PREADY &&
                         (wait_cnt == CNTW'(TIMEOUT_CYCLES - 1));
`else
    // Timeout logic compiled out; this is false for any legal TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            PSEL      <= psel_n;
            PENABLE   <= penable_n;
            PWRITE    <= pwrite_n;
            PADDR     <= paddr_n;
            PWDATA    <= pwdata_n;
            PSTRB     <= pstrb_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        psel_n      = PSEL;
        penable_n   = PENABLE;
        pwrite_n    = PWRITE;
        paddr_n     = PADDR;
        pwdata_n    = PWDATA;
        pstrb_n     = PSTRB;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_n  = cmd_addr;
                    pwrite_n = cmd_write;
                    pwdata_n = cmd_wdata;
                    pstrb_n  = cmd_write ? cmd_strb : '0;
                    psel_n   = 1'b1;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    if (PWRITE || RDATA_LAT == 0) begin
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b0;
                        rsp_rdata_n = PWRITE ? '0 : PRDATA;
                        state_n     = IDLE;
                    end else begin
                        state_n = RDWAIT;
                    end
                end else if (timeout_hit) begin
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_rdata_n = '0;
                    state_n     = IDLE;
                end
            end
            RDWAIT: begin
                // Registered-PRDATA slave presents read data one cycle after completion.
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_rdata_n = PRDATA;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: registered-PRDATA slave with wait states, transfer-timeline reference model.
module tb_apb_master_bridge;
    localparam int AW = 8, DW = 32, SW = 4, RDL = 1, TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          PCLK, PRESET, cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr, PADDR;
    logic [DW-1:0] cmd_wdata, rsp_rdata, PWDATA, PRDATA;
    logic [SW-1:0] cmd_strb, PSTRB;
    logic          rsp_valid, rsp_err, PSEL, PENABLE, PWRITE, PREADY;

    apb_master_bridge #(.ADDWIDTH(AW), .DATAWIDTH(DW), .RDATA_LAT(RDL), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA));

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        int            w;
        int            gap;
    } cmd_t;

    cmd_t          q[$];
    cmd_t          cur;
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] slv_mem [256];
    int            cyc = 0, acc_cyc = 0, slv_wait = 0, idle_cnt = 0, got_lat = -1;
    int            n_pass = 0, n_chk = 0;
    bit            active = 1'b0, rd_pend = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] got_rdata;
    logic          got_err;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] wd, logic [SW-1:0] st);
        logic [DW-1:0] r = old;
        for (int b = 0; b < SW; b++)
            if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Slave: w PREADY-low ACCESS cycles, then completes; read data appears one cycle later.
    always @(negedge PCLK) begin
        PRDATA = rd_pend ? slv_mem[rd_addr] : DW'($urandom);
        rd_pend = 1'b0;
        if (PSEL && PENABLE) begin
            if (slv_wait > 0) begin
                PREADY = 1'b0;
                slv_wait--;
            end else begin
                PREADY = 1'b1;
                if (PWRITE) slv_mem[PADDR] = merge(slv_mem[PADDR], PWDATA, PSTRB);
                else begin
                    rd_pend = 1'b1;
                    rd_addr = PADDR;
                end
            end
        end else begin
            PREADY = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic push(input bit wr, input int addr, input logic [DW-1:0] wd, input logic [SW-1:0] st,
                        input int w, input int gap);
        cmd_t c;
        c.wr = wr; c.addr = AW'(addr); c.wdata = wd; c.strb = st; c.w = w; c.gap = gap;
        q.push_back(c);
    endtask

    // Expected outputs derived from position in the transfer timeline relative to the accept cycle.
    task automatic compare_cycle();
        bit exp_sel = 0, exp_en = 0, exp_rv = 0, exp_rdy = 1, ab;
        int rel, acc_end, resp;
        if (active) begin
            ab      = TO_EN && cur.w >= TO;
            rel     = cyc - acc_cyc;
            acc_end = ab ? 2 + TO - 1 : 2 + cur.w;
            resp    = ab ? 2 + TO : 3 + cur.w + ((!cur.wr && RDL == 1) ? 1 : 0);
            exp_sel = rel >= 1 && rel <= acc_end;
            exp_en  = rel >= 2 && rel <= acc_end;
            exp_rdy = rel == 0 || rel >= resp;
            exp_rv  = rel == resp;
        end
        chk("PSEL", PSEL, exp_sel);
        chk("PENABLE", PENABLE, exp_en);
        chk("cmd_ready", cmd_ready, exp_rdy);
        chk("rsp_valid", rsp_valid, exp_rv);
        if (rsp_valid && active) begin
            got_lat = cyc - acc_cyc; got_rdata = rsp_rdata; got_err = rsp_err;
        end
        if (exp_sel) begin
            chk("PADDR", PADDR, cur.addr);
            chk("PWRITE", PWRITE, cur.wr);
            chk("PWDATA", PWDATA, cur.wdata);
            chk("PSTRB", PSTRB, cur.wr ? cur.strb : '0);
        end
        if (exp_rv) begin
            chk("rsp_err", rsp_err, ab);
            chk("rsp_rdata", rsp_rdata, (ab || cur.wr) ? '0 : ref_mem[cur.addr]);
            if (!ab && cur.wr) ref_mem[cur.addr] = merge(ref_mem[cur.addr], cur.wdata, cur.strb);
            active = 1'b0;
            idle_cnt = 0;
        end
    endtask

    task automatic drive();
        if (!active && q.size() > 0 && idle_cnt >= q[0].gap) begin
            cur = q.pop_front();
            cmd_valid = 1'b1; cmd_write = cur.wr; cmd_addr = cur.addr;
            cmd_wdata = cur.wdata; cmd_strb = cur.strb;
            acc_cyc = cyc; slv_wait = cur.w; active = 1'b1;
        end else begin
            // While busy the bridge must ignore the command port entirely.
            cmd_valid = active ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_write = 1'($urandom_range(0, 1)); cmd_addr = AW'($urandom);
            cmd_wdata = DW'($urandom); cmd_strb = SW'($urandom);
            if (!active) idle_cnt++;
        end
    endtask

    task automatic run(input int abort_rel, input int max_cyc);
        int n = 0;
        got_lat = -1;
        while ((q.size() > 0 || active) && n < max_cyc) begin
            @(negedge PCLK);
            n++;
            compare_cycle();
            if (active && abort_rel >= 0 && cyc - acc_cyc == abort_rel) return;
            drive();
        end
        if (n >= max_cyc) begin
            n_chk++;
            $display("FAIL run_budget: transfer still open after %0d cycles, required completion", n);
            active = 1'b0;
            q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_PSEL"}, PSEL, 0);       chk({tag, "_PENABLE"}, PENABLE, 0);
        chk({tag, "_PWRITE"}, PWRITE, 0);   chk({tag, "_PADDR"}, PADDR, 0);
        chk({tag, "_PWDATA"}, PWDATA, 0);   chk({tag, "_PSTRB"}, PSTRB, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0); chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0); chk({tag, "_cmd_ready"}, cmd_ready, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = '0; slv_mem[i] = '0;
        end
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk_reset_outputs("reset");
        PRESET = 1'b0;

        push(1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        run(-1, 50);
        chk("wr_latency", got_lat, 3);
        chk("wr_err", got_err, 0);
        push(0, 8'h10, 32'h0, 4'hF, 0, 0);
        run(-1, 50);
        chk("rd_latency", got_lat, 4);
        chk("rd_data", got_rdata, 32'hDEADBEEF);

        push(1, 8'h10, 32'h11223344, 4'b0101, 0, 0);
        push(0, 8'h10, 32'h0, 4'h0, 0, 0);
        run(-1, 50);
        chk("partial_strb_rd", got_rdata, 32'hDE22BE44);

        push(1, 8'h30, 32'hA5A5_0F0F, 4'hF, 3, 1);
        run(-1, 50);
        chk("wait3_wr_latency", got_lat, 6);

        // Abort a write in its ACCESS wait phase with an asynchronous reset.
        push(1, 8'h20, 32'h1234_5678, 4'hF, 6, 0);
        run(4, 50);
        #2 PRESET = 1'b1;
        cmd_valid = 1'b0;
        #1 chk_reset_outputs("midreset");
        active = 1'b0; slv_wait = 0; rd_pend = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        push(0, 8'h20, 32'h0, 4'h0, 0, 0);
        push(1, 8'h20, 32'hCAFEF00D, 4'hF, 1, 0);
        push(0, 8'h20, 32'h0, 4'h0, 2, 0);
        run(-1, 80);
        chk("after_reset_rd", got_rdata, 32'hCAFEF00D);
        chk("after_reset_rd_latency", got_lat, 6);

        if (TO_EN) begin
            push(0, 8'h10, 32'h0, 4'h0, TO + 3, 0);
            run(-1, 50);
            chk("timeout_latency", got_lat, 6);
            chk("timeout_err", got_err, 1);
            chk("timeout_rdata", got_rdata, 0);
        end

        for (int i = 0; i < 60; i++) begin
            int w = $urandom_range(0, 3);
            if (TO_EN && $urandom_range(0, 7) == 0) w = TO + 1;
            push(1'($urandom_range(0, 1)), $urandom_range(0, 7), DW'($urandom), SW'($urandom),
                 w, $urandom_range(0, 2));
        end
        run(-1, 2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
